signal_timer_arbiter: RTL

Shares the single interval timer (`traffictimer_bh`-style: clk/reset/cnt_ini/cnt_rst in, timer out) among up to NREQ phase and crossing controllers at an intersection. Requesters post a duration and hold a request. The arbiter grants round-robin, parks and loads the timer, waits for expiry, then returns a one-cycle done pulse to the winner. It sits between the per-road signal FSMs and the one timer instance, so adding a crossing or turn phase needs no extra timer.

---
 rtl/signal_timer_arbiter_if.sv | 31 +++
 rtl/signal_timer_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/signal_timer_arbiter_if.sv
// Signal bundle between the phase/crossing controllers, the shared interval
// timer and the arbiter that time-shares that timer among them.
interface signal_timer_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] dur;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [IDW-1:0]        active_id;
  logic                  tmr_reset;
  logic [NBITS-1:0]      tmr_cnt_ini;
  logic [NBITS-1:0]      tmr_cnt_rst;
  logic                  tmr_expired;

  // Requester/timer side: posts requests and durations, reports expiry
  modport master (
    output req, dur, tmr_expired,
    input  gnt, done, busy, active_id, tmr_reset, tmr_cnt_ini, tmr_cnt_rst
  );

  // Arbiter side
  modport slave (
    input  req, dur, tmr_expired,
    output gnt, done, busy, active_id, tmr_reset, tmr_cnt_ini, tmr_cnt_rst
  );
endinterface

// File: rtl/signal_timer_arbiter.sv
// Round-robin arbiter sharing one interval timer among NREQ signal phase and
// crossing controllers. The winner's duration is loaded into the timer, the
// arbiter waits for expiry and returns a one-cycle done pulse to the winner.
module signal_timer_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  signal_timer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW-1:0]   ptr_adv;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             cur_req;
  logic [IDW-1:0]   id_nxt;
  logic [NBITS-1:0] lim_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic [NREQ-1:0]  done_nxt;
  logic             busy_nxt;
  logic             tmr_reset_nxt;

  // The timer always restarts from zero; only its terminal value varies
  assign bus.tmr_cnt_ini = '0;

  // The winner keeps its grant only while its level request stays high
  assign cur_req = bus.req[bus.active_id];

  // Pointer moves just past the current winner once its interval ends
  assign ptr_adv = (bus.active_id == IDW'(NREQ - 1)) ? '0 : bus.active_id + 1'b1;

  // Round-robin search: first set request at ptr, ptr+1, ... wrapping at NREQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next state, next winner/duration and the registered outputs implied by the next state
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    id_nxt    = bus.active_id;
    lim_nxt   = bus.tmr_cnt_rst;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = LOAD;
          id_nxt    = pick;
          lim_nxt   = bus.dur[int'(pick)*NBITS +: NBITS];
        end
      end
      LOAD: begin
        if (!cur_req) begin
          state_nxt = IDLE;
          ptr_nxt   = ptr_adv;
        end else if (bus.tmr_cnt_rst == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.tmr_expired) begin
          state_nxt = DONE;
        end else if (!cur_req) begin
          state_nxt = IDLE;
          ptr_nxt   = ptr_adv;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ptr_nxt   = ptr_adv;
      end
      default: state_nxt = IDLE;
    endcase

    gnt_nxt  = '0;
    done_nxt = '0;
    if (state_nxt != IDLE) gnt_nxt[id_nxt] = 1'b1;
    if (state_nxt == DONE) done_nxt[id_nxt] = 1'b1;
    busy_nxt      = (state_nxt != IDLE);
    tmr_reset_nxt = (state_nxt != RUN);
  end

  // State register and registered outputs; reset parks the timer immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      bus.gnt         <= '0;
      bus.done        <= '0;
      bus.busy        <= 1'b0;
      bus.active_id   <= '0;
      bus.tmr_reset   <= 1'b1;
      bus.tmr_cnt_rst <= '0;
    end else begin
      state           <= state_nxt;
      ptr             <= ptr_nxt;
      bus.gnt         <= gnt_nxt;
      bus.done        <= done_nxt;
      bus.busy        <= busy_nxt;
      bus.active_id   <= id_nxt;
      bus.tmr_reset   <= tmr_reset_nxt;
      bus.tmr_cnt_rst <= lim_nxt;
    end
  end

endmodule
